// File: rtl/control.sv
// Shared sequencer types and microcode entry layout (payload, halt, load, next_instr, branch_en, branch_step).
// Latency: none, types and constants only.
// Backpressure: not applicable.
package control;

    localparam int DEF_OPCODE_WIDTH = 8;
    localparam int DEF_STEP_WIDTH   = 4;
    localparam int DEF_FLAG_WIDTH   = 2;
    localparam int DEF_CW_WIDTH     = 24;

    typedef enum logic {
        SEQ_HALTED  = 1'b0,
        SEQ_RUNNING = 1'b1
    } seq_state_e;

    // Layout at the default widths; the field offsets below hold for any width.
    typedef struct packed {
        logic [DEF_CW_WIDTH-1:0]   payload;
        logic                      halt;
        logic                      load;
        logic                      next_instr;
        logic                      branch_en;
        logic [DEF_STEP_WIDTH-1:0] branch_step;
    } ucode_entry_t;

    localparam int OFS_BRANCH_STEP = 0;

    function automatic int ofs_branch_en(input int step_width);
        return step_width;
    endfunction

    function automatic int ofs_next_instr(input int step_width);
        return step_width + 1;
    endfunction

    function automatic int ofs_load(input int step_width);
        return step_width + 2;
    endfunction

    function automatic int ofs_halt(input int step_width);
        return step_width + 3;
    endfunction

    function automatic int ofs_payload(input int step_width);
        return step_width + 4;
    endfunction

endpackage

// File: rtl/microcode_ram.sv
// Writable microcode store, one entry per {step, opcode, flags} address.
// Latency: read is combinational; a write lands at the clock edge and is readable the next cycle.
// Backpressure: none, a write strobe is always accepted.
module microcode_ram #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/microsequencer.sv
// Microcoded control unit: steps a micro-step counter and issues one registered control word per entry.
// Latency: 1 cycle from {step, opcode, flag} to control_word; first entry issued the cycle after run.
// Backpressure: stall freezes step, opcode and control_word; no entry is consumed while it is high.
module microsequencer
    import control::*;
#(
    parameter int  OPCODE_WIDTH = DEF_OPCODE_WIDTH,
    parameter int  STEP_WIDTH   = DEF_STEP_WIDTH,
    parameter int  FLAG_WIDTH   = DEF_FLAG_WIDTH,
    parameter int  CW_WIDTH     = DEF_CW_WIDTH,
    localparam int ADDR_WIDTH   = STEP_WIDTH + OPCODE_WIDTH + FLAG_WIDTH,
    localparam int ENTRY_WIDTH  = CW_WIDTH + 4 + STEP_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    stall,
    input  logic [OPCODE_WIDTH-1:0] bus,
    input  logic [FLAG_WIDTH-1:0]   alu_flag,
    input  logic                    ucode_we,
    input  logic [ADDR_WIDTH-1:0]   ucode_addr,
    input  logic [ENTRY_WIDTH-1:0]  ucode_wdata,
    output logic [CW_WIDTH-1:0]     control_word,
    output logic                    halted,
    output logic                    fault,
    output logic [STEP_WIDTH-1:0]   step,
    output logic [OPCODE_WIDTH-1:0] opcode
);

    localparam int OFS_BE      = ofs_branch_en(STEP_WIDTH);
    localparam int OFS_NI      = ofs_next_instr(STEP_WIDTH);
    localparam int OFS_LOAD    = ofs_load(STEP_WIDTH);
    localparam int OFS_HALT    = ofs_halt(STEP_WIDTH);
    localparam int OFS_PAYLOAD = ofs_payload(STEP_WIDTH);

    seq_state_e               state_q, state_d;
    logic [STEP_WIDTH-1:0]    step_d;
    logic [OPCODE_WIDTH-1:0]  opcode_d;
    logic [CW_WIDTH-1:0]      cw_d;
    logic                     fault_d;

    logic [ENTRY_WIDTH-1:0]   rd_entry;
    logic [CW_WIDTH-1:0]      e_payload;
    logic                     e_halt, e_load, e_next_instr, e_branch_en;
    logic [STEP_WIDTH-1:0]    e_branch_step;
    logic                     overflow;
    logic                     ram_we;

    // The store is only writable while halted so live microcode never changes under the sequencer.
    assign ram_we = ucode_we && (state_q == SEQ_HALTED);

    microcode_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(ENTRY_WIDTH)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (ucode_addr),
        .wdata (ucode_wdata),
        .raddr ({step, opcode, alu_flag}),
        .rdata (rd_entry)
    );

    assign e_payload     = rd_entry[OFS_PAYLOAD +: CW_WIDTH];
    assign e_halt        = rd_entry[OFS_HALT];
    assign e_load        = rd_entry[OFS_LOAD];
    assign e_next_instr  = rd_entry[OFS_NI];
    assign e_branch_en   = rd_entry[OFS_BE];
    assign e_branch_step = rd_entry[OFS_BRANCH_STEP +: STEP_WIDTH];

    assign overflow = (&step) && !(e_next_instr || e_branch_en || e_halt);
    assign halted   = (state_q == SEQ_HALTED);

    always_comb begin
        state_d  = state_q;
        step_d   = step;
        opcode_d = opcode;
        cw_d     = control_word;
        fault_d  = fault;
        unique case (state_q)
            SEQ_HALTED: begin
                cw_d = '0;
                if (run) begin
                    state_d = SEQ_RUNNING;
                    fault_d = 1'b0;
                end
            end
            SEQ_RUNNING: begin
                if (!stall) begin
                    if (overflow) begin
                        // Running off the end of the step space drops the entry rather than issuing it.
                        state_d = SEQ_HALTED;
                        fault_d = 1'b1;
                        step_d  = '0;
                        cw_d    = '0;
                    end else begin
                        cw_d = e_payload;
                        if (e_load) begin
                            opcode_d = bus;
                        end
                        if (e_next_instr || e_halt) begin
                            step_d = '0;
                        end else if (e_branch_en) begin
                            step_d = e_branch_step;
                        end else begin
                            step_d = step + STEP_WIDTH'(1);
                        end
                        if (e_halt) begin
                            state_d = SEQ_HALTED;
                        end
                    end
                end
            end
            default: state_d = SEQ_HALTED;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= SEQ_HALTED;
            step         <= '0;
            opcode       <= '0;
            control_word <= '0;
            fault        <= 1'b0;
        end else begin
            state_q      <= state_d;
            step         <= step_d;
            opcode       <= opcode_d;
            control_word <= cw_d;
            fault        <= fault_d;
        end
    end

endmodule
